misao_branch_unit: RTL and testbench

Parametrised program-counter and branch-resolution unit for the MISA-O core. It replaces the fixed 4-bit-offset, single-condition PC update with a handshaked branch port, selectable conditions, a return-address stack, and a counted fetch flush. It sits between decode (branch requests) and fetch (the `fetch_addr` and `redirect`/`flush` outputs).

---
 rtl/misao_br_pkg.sv | 21 ++
 rtl/misao_ras.sv | 56 +++++
 rtl/misao_branch_unit.sv | 164 ++++++++++++++++
 tb/tb_misao_branch_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/misao_br_pkg.sv
// MISA-O branch unit shared types: branch opcodes and control states.
package misao_br_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQZ = 3'd1,
        BR_BC   = 3'd2,
        BR_BTST = 3'd3,
        BR_JAL  = 3'd4,
        BR_JMP  = 3'd5,
        BR_RET  = 3'd6
    } br_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESOLVE,
        ST_REDIRECT,
        ST_FLUSH
    } br_st_t;

endpackage

// File: rtl/misao_ras.sv
// Circular return-address stack; full pushes overwrite the oldest entry.
module misao_ras #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     ovf,
    output logic                     unf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] top_idx;

    // ptr_q is the next free slot; the top sits just below it
    assign top_idx = ptr_q - PTR_W'(1);
    assign top     = mem[top_idx];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (cnt == CW'(DEPTH)) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else if (pop) begin
            if (cnt == '0) begin
                unf <= 1'b1;
            end else begin
                ptr_q <= ptr_q - PTR_W'(1);
                cnt   <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/misao_branch_unit.sv
// MISA-O program counter and branch resolution with return-address
// stack and counted fetch flush.
module misao_branch_unit
    import misao_br_pkg::*;
#(
    parameter int          ADDR_W    = 15,
    parameter int          DATA_W    = 16,
    parameter int          OFF_W     = 4,
    parameter int          RAS_DEPTH = 4,
    parameter int          FLUSH_CYC = 2,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic [1:0]                 adv,
    input  logic                       br_valid,
    output logic                       br_ready,
    input  br_op_t                     br_op,
    input  logic [ADDR_W:0]            br_pc,
    input  logic [OFF_W-1:0]           br_off,
    input  logic [DATA_W-1:0]          acc,
    input  logic                       flag_c,
    input  logic                       flag_t,
    output logic [ADDR_W:0]            pc,
    output logic [ADDR_W-1:0]          fetch_addr,
    output logic                       redirect,
    output logic                       flush,
    output logic                       taken,
    output logic [$clog2(RAS_DEPTH):0] ras_cnt,
    output logic                       ras_ovf,
    output logic                       ras_unf
);
    localparam int              PW     = ADDR_W + 1;
    localparam int              CW     = $clog2(FLUSH_CYC + 1);
    localparam logic [PW-1:0]   RST_PC = PW'(RESET_PC);

    br_st_t             st_q;
    br_st_t             st_d;
    br_op_t             op_q;
    logic [PW-1:0]      pc_q;
    logic [PW-1:0]      bpc_q;
    logic [PW-1:0]      link_q;
    logic [PW-1:0]      tgt_q;
    logic [PW-1:0]      tgt;
    logic [PW-1:0]      off_x;
    logic [PW-1:0]      step;
    logic [PW-1:0]      ras_top;
    logic [OFF_W-1:0]   off_q;
    logic [DATA_W-1:0]  acc_q;
    logic               c_q;
    logic               t_q;
    logic               cond;
    logic               push;
    logic               pop;
    logic [CW-1:0]      cnt_q;

    assign br_ready   = (st_q == ST_IDLE);
    assign taken      = (st_q == ST_RESOLVE) && cond;
    assign redirect   = (st_q == ST_REDIRECT);
    assign flush      = redirect || (st_q == ST_FLUSH);
    // the target is presented during REDIRECT, before pc_q takes it
    assign pc         = redirect ? tgt_q : pc_q;
    assign fetch_addr = pc[ADDR_W:1];
    assign step       = (adv == 2'd3) ? PW'(2) : PW'(adv);
    assign off_x      = PW'($signed(off_q));
    assign push       = (st_q == ST_RESOLVE) && (op_q == BR_JAL);
    assign pop        = (st_q == ST_RESOLVE) && (op_q == BR_RET);

    always_comb begin
        cond = 1'b0;
        tgt  = bpc_q + (off_x << 1);
        unique case (op_q)
            BR_BEQZ: cond = (acc_q == '0);
            BR_BC:   cond = c_q;
            BR_BTST: cond = t_q;
            BR_JAL, BR_JMP: begin
                cond = 1'b1;
                tgt  = PW'(acc_q);
            end
            BR_RET: begin
                cond = 1'b1;
                tgt  = (ras_cnt == '0) ? RST_PC : ras_top;
            end
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            ST_IDLE:     if (br_valid) st_d = ST_RESOLVE;
            ST_RESOLVE:  st_d = cond ? ST_REDIRECT : ST_IDLE;
            ST_REDIRECT: st_d = (FLUSH_CYC > 1) ? ST_FLUSH : ST_IDLE;
            ST_FLUSH: begin
                if (!stall && cnt_q <= CW'(1)) st_d = ST_IDLE;
            end
            default:     st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= RST_PC;
            op_q   <= BR_NONE;
            bpc_q  <= '0;
            off_q  <= '0;
            acc_q  <= '0;
            c_q    <= 1'b0;
            t_q    <= 1'b0;
            link_q <= '0;
            tgt_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (br_valid && br_ready) begin
                op_q   <= br_op;
                bpc_q  <= br_pc;
                off_q  <= br_off;
                acc_q  <= acc;
                c_q    <= flag_c;
                t_q    <= flag_t;
                link_q <= br_pc + PW'(1);
            end
            if (st_q == ST_RESOLVE) begin
                tgt_q <= tgt;
            end
            if (st_q == ST_REDIRECT) begin
                pc_q  <= tgt_q;
                cnt_q <= CW'(FLUSH_CYC - 1);
            end else begin
                if (!stall) begin
                    pc_q <= pc_q + step;
                end
                if (st_q == ST_FLUSH && !stall && cnt_q != '0) begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end

    misao_ras #(
        .W     (PW),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (link_q),
        .top  (ras_top),
        .cnt  (ras_cnt),
        .ovf  (ras_ovf),
        .unf  (ras_unf)
    );

endmodule

// File: tb/tb_misao_branch_unit.sv
// Scoreboard bench for misao_branch_unit: directed and random branches
// checked against a queue-based reference model.
module tb_misao_branch_unit;
    import misao_br_pkg::*;

    localparam int          ADDR_W    = 15;
    localparam int          DATA_W    = 16;
    localparam int          OFF_W     = 4;
    localparam int          RAS_DEPTH = 4;
    localparam int          FLUSH_CYC = 2;
    localparam int unsigned RESET_PC  = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [1:0]  adv = 2'd0;
    logic        br_valid = 1'b0;
    logic        br_ready;
    br_op_t      br_op = BR_NONE;
    logic [15:0] br_pc = '0;
    logic [3:0]  br_off = '0;
    logic [15:0] acc = '0;
    logic        flag_c = 1'b0;
    logic        flag_t = 1'b0;
    logic [15:0] pc;
    logic [14:0] fetch_addr;
    logic        redirect;
    logic        flush;
    logic        taken;
    logic [2:0]  ras_cnt;
    logic        ras_ovf;
    logic        ras_unf;

    always #5 clk = ~clk;

    misao_branch_unit #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .OFF_W     (OFF_W),
        .RAS_DEPTH (RAS_DEPTH),
        .FLUSH_CYC (FLUSH_CYC),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .adv        (adv),
        .br_valid   (br_valid),
        .br_ready   (br_ready),
        .br_op      (br_op),
        .br_pc      (br_pc),
        .br_off     (br_off),
        .acc        (acc),
        .flag_c     (flag_c),
        .flag_t     (flag_t),
        .pc         (pc),
        .fetch_addr (fetch_addr),
        .redirect   (redirect),
        .flush      (flush),
        .taken      (taken),
        .ras_cnt    (ras_cnt),
        .ras_ovf    (ras_ovf),
        .ras_unf    (ras_unf)
    );

    typedef struct packed {
        logic        tk;
        logic [15:0] tgt;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] ras_m[$];
    logic        ovf_m = 1'b0;
    logic        unf_m = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          stall_mode = 0;

    int          ph = 0;
    exp_t        cur;
    logic [15:0] m_pc = '0;
    logic [15:0] prev_step = '0;
    logic        prev_red = 1'b0;
    logic        red_exp;
    logic        idle;
    int          fl_len = 0;
    int          fl_st = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Reference model: condition, target and stack from the branch rules
    task automatic model(br_op_t op, logic [15:0] bpc, logic [3:0] off,
                         logic [15:0] a, logic c, logic t);
        exp_t e;
        int   soff;
        soff  = off[3] ? int'(off) - 16 : int'(off);
        e.tk  = 1'b0;
        e.tgt = 16'(int'(bpc) + 2 * soff);
        case (op)
            BR_BEQZ: e.tk = (a == 16'd0);
            BR_BC:   e.tk = c;
            BR_BTST: e.tk = t;
            BR_JAL: begin
                e.tk  = 1'b1;
                e.tgt = a;
                ras_m.push_back(bpc + 16'd1);
                if (ras_m.size() > RAS_DEPTH) begin
                    void'(ras_m.pop_front());
                    ovf_m = 1'b1;
                end
            end
            BR_JMP: begin
                e.tk  = 1'b1;
                e.tgt = a;
            end
            BR_RET: begin
                e.tk = 1'b1;
                if (ras_m.size() == 0) begin
                    e.tgt = 16'(RESET_PC);
                    unf_m = 1'b1;
                end else begin
                    e.tgt = ras_m.pop_back();
                end
            end
            default: e.tk = 1'b0;
        endcase
        e.cnt = 3'(ras_m.size());
        e.ovf = ovf_m;
        e.unf = unf_m;
        expq.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        adv = 2'($urandom_range(0, 3));
        if (stall_mode == 0) stall = 1'b0;
        else if (stall_mode == 1) stall = ($urandom_range(0, 3) == 0);
    endtask

    task automatic issue(br_op_t op, logic [15:0] bpc, logic [3:0] off,
                         logic [15:0] a, logic c, logic t);
        br_op    = op;
        br_pc    = bpc;
        br_off   = off;
        acc      = a;
        flag_c   = c;
        flag_t   = t;
        br_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (br_ready) break;
            cycle();
        end
        if (!br_ready) begin
            fail_now("issue_wait");
            br_valid = 1'b0;
            return;
        end
        model(op, bpc, off, a, c, t);
        cycle();
        br_valid = 1'b0;
        br_op    = br_op_t'(3'($urandom_range(0, 7)));
        br_pc    = 16'($urandom);
        br_off   = 4'($urandom);
        acc      = 16'($urandom);
        flag_c   = 1'($urandom);
        flag_t   = 1'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 60; k++) begin
            if (br_ready && ph == 0 && expq.size() == 0) break;
            cycle();
        end
        if (k >= 60) fail_now("idle_wait");
    endtask

    task automatic wait_red();
        int k;
        for (k = 0; k < 10; k++) begin
            if (redirect) break;
            cycle();
        end
        if (k >= 10) fail_now("redirect_wait");
    endtask

    // Monitor: follows the handshake and pops one expectation per branch
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_pc", 32'(pc), 32'(RESET_PC));
                chk("rst_ready", 32'(br_ready), 32'd1);
                chk("rst_pulses", 32'({redirect, flush, taken}), 32'd0);
                ph       = 0;
                m_pc     = 16'(RESET_PC);
                prev_red = 1'b0;
            end else begin
                red_exp = (ph == 2);
                if (red_exp) m_pc = cur.tgt;
                else if (!prev_red) m_pc = m_pc + prev_step;
                chk("pc", 32'(pc), 32'(m_pc));
                chk("fetch_addr", 32'(fetch_addr), 32'(m_pc[15:1]));
                idle = 1'b0;
                case (ph)
                    0: begin
                        chk("idle_quiet", 32'({redirect, flush, taken}), 32'd0);
                        chk("idle_ready", 32'(br_ready), 32'd1);
                        idle = 1'b1;
                    end
                    1: begin
                        chk("resolve_ready", 32'(br_ready), 32'd0);
                        if (expq.size() == 0) begin
                            fail_now("resolve_no_expectation");
                            ph = 0;
                        end else begin
                            cur = expq.pop_front();
                            chk("taken", 32'(taken), 32'(cur.tk));
                            ph = cur.tk ? 2 : 3;
                        end
                    end
                    2: begin
                        chk("redirect", 32'(redirect), 32'd1);
                        chk("flush_start", 32'(flush), 32'd1);
                        chk("ras_cnt", 32'(ras_cnt), 32'(cur.cnt));
                        chk("ras_flags", 32'({ras_ovf, ras_unf}),
                            32'({cur.ovf, cur.unf}));
                        fl_len = 1;
                        fl_st  = 0;
                        ph     = 4;
                    end
                    3: begin
                        chk("nt_quiet", 32'({redirect, flush, taken}), 32'd0);
                        chk("nt_ready", 32'(br_ready), 32'd1);
                        chk("ras_cnt", 32'(ras_cnt), 32'(cur.cnt));
                        chk("ras_flags", 32'({ras_ovf, ras_unf}),
                            32'({cur.ovf, cur.unf}));
                        ph   = 0;
                        idle = 1'b1;
                    end
                    4: begin
                        if (flush) begin
                            fl_len++;
                            if (stall) fl_st++;
                            chk("flush_hold",
                                32'({redirect, br_ready, taken}), 32'd0);
                        end else begin
                            chk("flush_len", 32'(fl_len), 32'(FLUSH_CYC + fl_st));
                            chk("flush_ready", 32'(br_ready), 32'd1);
                            ph   = 0;
                            idle = 1'b1;
                        end
                    end
                    default: ph = 0;
                endcase
                if (idle && br_valid && br_ready) ph = 1;
                prev_red = red_exp;
            end
            prev_step = stall ? 16'd0 : ((adv == 2'd3) ? 16'd2 : 16'(adv));
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        br_op_t      op;
        logic [15:0] a;
        #2;
        chk("reset_pc", 32'(pc), 32'(RESET_PC));
        chk("reset_fetch", 32'(fetch_addr), 32'(RESET_PC >> 1));
        chk("reset_ready", 32'(br_ready), 32'd1);
        chk("reset_ras_cnt", 32'(ras_cnt), 32'd0);
        chk("reset_ras_flags", 32'({ras_ovf, ras_unf}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        cycle();

        issue(BR_BEQZ, 16'd6, 4'd2, 16'd0, 1'b0, 1'b0);
        wait_idle();
        issue(BR_BEQZ, 16'd14, 4'd2, 16'd1, 1'b1, 1'b1);
        wait_idle();
        issue(BR_BTST, 16'd2, 4'hC, 16'h0055, 1'b0, 1'b1);
        wait_idle();

        for (int i = 1; i <= 5; i++) begin
            issue(BR_JAL, 16'(i * 16), 4'($urandom), 16'($urandom), 1'b0, 1'b0);
        end
        wait_idle();
        chk("jal5_ovf", 32'(ras_ovf), 32'd1);
        chk("jal5_cnt", 32'(ras_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            issue(BR_RET, 16'($urandom), 4'($urandom), 16'($urandom), 1'b0, 1'b0);
        end
        wait_idle();
        issue(BR_RET, 16'h0300, 4'd0, 16'h1111, 1'b0, 1'b0);
        wait_idle();
        chk("ret_unf", 32'(ras_unf), 32'd1);
        chk("ret_cnt", 32'(ras_cnt), 32'd0);

        issue(BR_JMP, 16'h0000, 4'd0, 16'h0400, 1'b0, 1'b0);
        wait_red();
        stall_mode = 2;
        cycle();
        stall = 1'b1;
        cycle();
        cycle();
        cycle();
        stall = 1'b0;
        stall_mode = 0;
        wait_idle();

        issue(BR_JAL, 16'h0100, 4'd0, 16'h0200, 1'b0, 1'b0);
        wait_red();
        rst = 1'b0;
        #1;
        chk("midred_pc", 32'(pc), 32'(RESET_PC));
        chk("midred_flush", 32'({flush, redirect}), 32'd0);
        chk("midred_ready", 32'(br_ready), 32'd1);
        chk("midred_ras", 32'({ras_cnt, ras_ovf, ras_unf}), 32'd0);
        expq.delete();
        ras_m.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        cycle();

        stall_mode = 1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 3)) cycle();
            op = br_op_t'(3'($urandom_range(0, 7)));
            a  = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom);
            issue(op, 16'($urandom), 4'($urandom), a,
                  1'($urandom), 1'($urandom));
        end
        stall_mode = 0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
